// File: rtl/sound_arbiter.sv
// ---------------------------------------------------------------------------
// sound_arbiter
//
// Shares the single sound-playback channel (6-bit selection code plus reset
// strobe) between NREQ game-logic requesters. Fixed priority, index 0 is the
// highest. A granted sound gets a RST_CYCLES reset pulse, then at least
// PLAY_CYCLES of play time, then one silent GAP cycle before the next grant.
//
// Optional feature (macro SOUND_ARB_PREEMPT_EN):
//   defined     - a higher-priority request preempts a sound in RST/PLAY.
//   not defined - every sound runs its full window.
//
// Ports:
//   PCLK      in   1        clock
//   PRESET    in   1        asynchronous, active-high reset
//   req       in   NREQ     level request per requester, held until acked
//   code      in   6*NREQ   sound code per requester (code[6i+5:6i])
//   ack       out  NREQ     one-cycle grant pulse
//   busy      out  1        channel in use (state is not IDLE)
//   owner     out  NREQ     one-hot current owner, zero in IDLE/GAP
//   selection out  6        code to the player, 6'b111111 = silence
//   reset     out  1        player restart strobe
//
// Handshake: req[i] is a level. The grant edge raises ack[i] for exactly one
// cycle; the requester drops req[i] once it has seen ack[i]. A req still high
// when the arbiter is back in IDLE is treated as a new request.
// ---------------------------------------------------------------------------
module sound_arbiter #(
  parameter int NREQ        = 4,
  parameter int RST_CYCLES  = 8,
  parameter int PLAY_CYCLES = 1000000,
  parameter int CNT_W       = 24
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [NREQ-1:0]   req,
  input  logic [6*NREQ-1:0] code,
  output logic [NREQ-1:0]   ack,
  output logic              busy,
  output logic [NREQ-1:0]   owner,
  output logic [5:0]        selection,
  output logic              reset
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RST  = 2'd1;
  localparam logic [1:0] S_PLAY = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  localparam logic [5:0]       SILENCE   = 6'b111111;
  localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] PLAY_LOAD = CNT_W'(PLAY_CYCLES - 1);

  // FSM state; kept as a plainly named signal so checkers can bind to it.
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  // Lowest set index of v (0 when v is empty; callers qualify with |v).
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NREQ-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    return NREQ'(1) << idx;
  endfunction

  logic [IDX_W-1:0] gnt_idx;
  logic [5:0]       gnt_code;

  assign gnt_idx  = lowest_idx(req);
  assign gnt_code = code[6*gnt_idx +: 6];

`ifdef SOUND_ARB_PREEMPT_EN
  logic [NREQ-1:0]  pre_req;
  logic [IDX_W-1:0] pre_idx;
  logic [5:0]       pre_code;
  logic             preempt;

  // owner is one-hot while in RST/PLAY, so owner-1 is the mask of strictly
  // higher-priority indices; the owner's own bit and everything below it
  // are excluded.
  assign pre_req  = req & (owner - NREQ'(1));
  assign preempt  = ((state == S_RST) || (state == S_PLAY)) && (|pre_req);
  assign pre_idx  = lowest_idx(pre_req);
  assign pre_code = code[6*pre_idx +: 6];
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ack       <= '0;
      busy      <= 1'b0;
      owner     <= '0;
      selection <= SILENCE;
      reset     <= 1'b0;
    end else begin
      ack <= '0;
`ifdef SOUND_ARB_PREEMPT_EN
      if (preempt) begin
        ack[pre_idx] <= 1'b1;
        if (pre_code == SILENCE) begin
          // Silence from a higher-priority requester just ends the sound.
          selection <= SILENCE;
          owner     <= '0;
          reset     <= 1'b0;
          cnt       <= '0;
          state     <= S_GAP;
        end else begin
          owner     <= onehot(pre_idx);
          selection <= pre_code;
          reset     <= 1'b1;
          cnt       <= RST_LOAD;
          state     <= S_RST;
        end
      end else
`endif
      case (state)
        S_IDLE: begin
          if (|req) begin
            ack[gnt_idx] <= 1'b1;
            // A silence code is acknowledged but never takes the channel.
            if (gnt_code != SILENCE) begin
              owner     <= onehot(gnt_idx);
              selection <= gnt_code;
              reset     <= 1'b1;
              cnt       <= RST_LOAD;
              busy      <= 1'b1;
              state     <= S_RST;
            end
          end
        end
        S_RST: begin
          if (cnt == '0) begin
            reset <= 1'b0;
            cnt   <= PLAY_LOAD;
            state <= S_PLAY;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_PLAY: begin
          if (cnt == '0) begin
            selection <= SILENCE;
            owner     <= '0;
            state     <= S_GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          // GAP: one guaranteed silent cycle between sounds.
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sound_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sound_arbiter
//
// Bench for sound_arbiter with short timing (RST_CYCLES=3, PLAY_CYCLES=5).
// The reference model tracks each sound as a time window: a grant at edge g
// owns selection over edges g..g+R+P-1, reset over g..g+R-1, busy until
// g+R+P, and the next grant may come at g+R+P+2. Grants are pushed as
// expected acks into exp_q; the negedge monitor pops them when the DUT acks
// and compares the other outputs against the active window every cycle.
// ---------------------------------------------------------------------------
module tb_sound_arbiter;

  localparam int NREQ = 4;
  localparam int R    = 3;
  localparam int P    = 5;
  localparam int CW   = 8;
  localparam logic [5:0] SIL = 6'h3f;

  logic              PCLK = 1'b0;
  logic              PRESET;
  logic [NREQ-1:0]   req;
  logic [6*NREQ-1:0] code;
  logic [NREQ-1:0]   ack;
  logic              busy;
  logic [NREQ-1:0]   owner;
  logic [5:0]        selection;
  logic              reset;

  sound_arbiter #(
    .NREQ(NREQ), .RST_CYCLES(R), .PLAY_CYCLES(P), .CNT_W(CW)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .req(req), .code(code), .ack(ack),
    .busy(busy), .owner(owner), .selection(selection), .reset(reset)
  );

  // ---------------- clock ----------------
  always #5 PCLK = ~PCLK;

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [16+NREQ-1:0] exp_q[$];   // {edge stamp, one-hot ack}

  int t         = 0;
  int sel_last  = -1;
  int rst_last  = -1;
  int busy_last = -1;
  int free_at   = 0;
  int pre_first = 0;
  int pre_last  = -1;
  int cur_idx   = 0;
  logic [5:0] cur_code = SIL;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at t=%0d: got %h expected %h", name, t, act, exp);
    end
  endtask

  function automatic int lowest(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic start_sound(input int i, input logic [5:0] c);
    cur_idx   = i;
    cur_code  = c;
    rst_last  = t + R - 1;
    sel_last  = t + R + P - 1;
    busy_last = t + R + P;
    free_at   = t + R + P + 2;
    pre_first = t + 1;
    pre_last  = t + R + P;
  endtask

  // ---------------- reference model ----------------
  always @(posedge PCLK or posedge PRESET) begin
    int j;
    logic [5:0] c;
    if (PRESET) begin
      t = 0; sel_last = -1; rst_last = -1; busy_last = -1; free_at = 0;
      pre_first = 0; pre_last = -1; cur_idx = 0; cur_code = SIL;
      exp_q.delete();
    end else begin
      t = t + 1;
      j = -1;
`ifdef SOUND_ARB_PREEMPT_EN
      if (t >= pre_first && t <= pre_last) begin
        j = lowest(req & ((NREQ'(1) << cur_idx) - NREQ'(1)));
        if (j >= 0) begin
          c = code[6*j +: 6];
          exp_q.push_back({16'(t), NREQ'(1) << j});
          if (c == SIL) begin
            sel_last  = t - 1;
            if (rst_last >= t) rst_last = t - 1;
            busy_last = t;
            free_at   = t + 2;
            pre_last  = -1;
          end else begin
            start_sound(j, c);
          end
        end
      end
`endif
      if (j < 0 && t >= free_at) begin
        j = lowest(req);
        if (j >= 0) begin
          c = code[6*j +: 6];
          exp_q.push_back({16'(t), NREQ'(1) << j});
          if (c != SIL) start_sound(j, c);
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge PCLK) begin
    logic [16+NREQ-1:0] e;
    logic [NREQ-1:0] exp_owner;
    logic [5:0] exp_sel;
    if (!PRESET) begin
      exp_owner = (t <= sel_last) ? (NREQ'(1) << cur_idx) : '0;
      exp_sel   = (t <= sel_last) ? cur_code : SIL;
      check("outputs{busy,owner,sel,reset}", {busy, owner, selection, reset},
            {(t <= busy_last), exp_owner, exp_sel, (t <= rst_last)});
      if (ack != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 32'(ack), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("ack{stamp,ack}", {16'(t), ack}, e);
        end
      end else if (exp_q.size() != 0 && exp_q[0][16+NREQ-1:NREQ] <= 16'(t)) begin
        e = exp_q.pop_front();
        check("missing_ack{stamp,ack}", {16'(t), ack}, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Requesters drop their req as soon as they see their ack.
  task automatic tick();
    @(negedge PCLK);
    req = req & ~ack;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_selection"}, 32'(selection), 32'(SIL));
    check({tag, "_reset"}, 32'(reset), 32'd0);
    check({tag, "_ack"}, 32'(ack), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_owner"}, 32'(owner), 32'd0);
  endtask

  task automatic async_reset_pulse(input string tag);
    #2 PRESET = 1'b1;
    #1 reset_checks(tag);
    tick();
    #2 PRESET = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    PRESET = 1'b1;
    req    = '0;
    code   = '0;
    repeat (3) @(negedge PCLK);
    #1 reset_checks("por");
    #1 PRESET = 1'b0;

    // single request, requester 2, code 5
    tick(); code[17:12] = 6'd5; req[2] = 1'b1;
    repeat (R + P + 4) tick();

    // tie between requesters 1 and 3
    code[11:6] = 6'd20; code[23:18] = 6'd33; req[1] = 1'b1; req[3] = 1'b1;
    repeat (2 * (R + P + 2) + 4) tick();

    // silence code from requester 0
    code[5:0] = SIL; req[0] = 1'b1;
    repeat (4) tick();

    // requester 0 arrives while requester 3 is in PLAY
    code[23:18] = 6'd9; req[3] = 1'b1;
    repeat (R + 2) tick();
    code[5:0] = 6'd12; req[0] = 1'b1;
    repeat (2 * (R + P + 2) + 4) tick();

    // asynchronous reset in the middle of RST with requester 2 still waiting
    code[17:12] = 6'd7; req[2] = 1'b1;
    tick();
    req[2] = 1'b1;
    async_reset_pulse("mid_rst");
    repeat (R + P + 4) tick();

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 5) == 0) begin
            code[6*i +: 6] = ($urandom_range(0, 7) == 0) ? SIL : 6'($urandom_range(0, 62));
            req[i] = 1'b1;
          end
        end else if ($urandom_range(0, 19) == 0) begin
          req[i] = 1'b0;
        end else if ($urandom_range(0, 9) == 0) begin
          code[6*i +: 6] = 6'($urandom_range(0, 63));
        end
      end
      if ($urandom_range(0, 299) == 0) async_reset_pulse("rand_rst");
    end

    // drain
    tick();
    req = '0;
    repeat (R + P + 4) tick();
    check("drain_exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
